// File: rtl/oflow_score_calc_multi_sm_fsm_if.sv
// Handshake bundle between registration/buffer control and the score-calc sequencer.
interface oflow_score_calc_multi_sm_fsm_if #(
  parameter int NUM_SM  = 2,
  parameter int ROUND_W = 8
);
  logic              start_score_calc;
  logic              abort;
  logic              done_read;
  logic [NUM_SM-1:0] valid_mask;
  logic [NUM_SM-1:0] done_similarity_metric;
  logic [NUM_SM-1:0] start_similarity_metric;
  logic              done_score_calc;
  logic              busy;
  logic [ROUND_W-1:0] round_cnt;
  logic              spurious_done;

  modport master (
    output start_score_calc, abort, done_read, valid_mask, done_similarity_metric,
    input  start_similarity_metric, done_score_calc, busy, round_cnt, spurious_done
  );

  modport slave (
    input  start_score_calc, abort, done_read, valid_mask, done_similarity_metric,
    output start_similarity_metric, done_score_calc, busy, round_cnt, spurious_done
  );
endinterface

// File: rtl/oflow_score_calc_multi_sm_fsm.sv
// Round sequencer for NUM_SM similarity-metric units: issues start rounds, tracks
// per-unit completion, and flags done pulses from units that were not started.

module oflow_score_calc_lane (
  input  logic clk,
  input  logic reset_N,
  input  logic flush,
  input  logic load,
  input  logic issue,
  input  logic track,
  input  logic done,
  output logic remaining,
  output logic spur
);
  logic pending;

  assign remaining = pending & ~done;
  assign spur      = done & ~(pending & track);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)   pending <= 1'b0;
    else if (flush) pending <= 1'b0;
    else if (load)  pending <= issue;
    else if (track) pending <= remaining;
  end
endmodule

module oflow_score_calc_multi_sm_fsm #(
  parameter int NUM_SM  = 2,
  parameter int ROUND_W = 8
) (
  input logic clk,
  input logic reset_N,
  oflow_score_calc_multi_sm_fsm_if.slave sc
);
  typedef enum logic [1:0] {IDLE_ST, ISSUE_ST, WAIT_ST} state_t;

  state_t            state;
  logic              last;
  logic [NUM_SM-1:0] issue_mask, remaining, spur;
  logic              track, complete, accept, fin, issue_now, spur_any;

  assign issue_mask = sc.valid_mask | NUM_SM'(1);
  assign track      = (state != IDLE_ST);
  assign complete   = (state == WAIT_ST) && (remaining == '0);
  assign accept     = (state == IDLE_ST) && sc.start_score_calc && !sc.abort;
  // Completion uses the registered last, so a coincident done_read applies to the next one.
  assign fin        = complete && last && !sc.abort;
  assign issue_now  = accept || (complete && !last && !sc.abort);
  assign spur_any   = |spur;

  genvar g;
  generate
    for (g = 0; g < NUM_SM; g++) begin : g_lane
      oflow_score_calc_lane u_lane (
        .clk       (clk),
        .reset_N   (reset_N),
        .flush     (sc.abort),
        .load      (issue_now),
        .issue     (issue_mask[g]),
        .track     (track),
        .done      (sc.done_similarity_metric[g]),
        .remaining (remaining[g]),
        .spur      (spur[g])
      );
    end
  endgenerate

  // Pulses are gated by reset so an asserted reset silences them immediately.
  assign sc.start_similarity_metric = (issue_now && reset_N) ? issue_mask : '0;
  assign sc.done_score_calc         = fin && reset_N;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state            <= IDLE_ST;
      last             <= 1'b0;
      sc.busy          <= 1'b0;
      sc.round_cnt     <= '0;
      sc.spurious_done <= 1'b0;
    end else begin
      if (accept)        sc.spurious_done <= spur_any;
      else if (spur_any) sc.spurious_done <= 1'b1;

      if (sc.abort) begin
        state        <= IDLE_ST;
        last         <= 1'b0;
        sc.busy      <= 1'b0;
        sc.round_cnt <= '0;
      end else begin
        if (sc.done_read) last <= 1'b1;
        else if (fin)     last <= 1'b0;

        case (state)
          IDLE_ST: if (sc.start_score_calc) begin
            state        <= ISSUE_ST;
            sc.busy      <= 1'b1;
            sc.round_cnt <= ROUND_W'(1);
          end
          ISSUE_ST: state <= WAIT_ST;
          WAIT_ST: if (complete) begin
            if (last) begin
              state   <= IDLE_ST;
              sc.busy <= 1'b0;
            end else begin
              state <= ISSUE_ST;
              if (sc.round_cnt != '1) sc.round_cnt <= sc.round_cnt + ROUND_W'(1);
            end
          end
          default: state <= IDLE_ST;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oflow_score_calc_multi_sm_fsm.sv
// Scoreboard bench: stimulus pushes expected start/done events, a negedge monitor pops them.
module tb_oflow_score_calc_multi_sm_fsm;
  logic clk = 1'b0;
  logic reset_N;
  always #5 clk = ~clk;

  logic       s_start, s_abort, s_done_read;
  logic [3:0] s_vmask, s_done;

  oflow_score_calc_multi_sm_fsm_if #(.NUM_SM(4), .ROUND_W(8)) sc1 ();
  oflow_score_calc_multi_sm_fsm_if #(.NUM_SM(4), .ROUND_W(2)) sc2 ();

  assign sc1.start_score_calc       = s_start;
  assign sc1.abort                  = s_abort;
  assign sc1.done_read              = s_done_read;
  assign sc1.valid_mask             = s_vmask;
  assign sc1.done_similarity_metric = s_done;
  assign sc2.start_score_calc       = s_start;
  assign sc2.abort                  = s_abort;
  assign sc2.done_read              = s_done_read;
  assign sc2.valid_mask             = s_vmask;
  assign sc2.done_similarity_metric = s_done;

  oflow_score_calc_multi_sm_fsm #(.NUM_SM(4), .ROUND_W(8)) dut (
    .clk(clk), .reset_N(reset_N), .sc(sc1));
  oflow_score_calc_multi_sm_fsm #(.NUM_SM(4), .ROUND_W(2)) dut2 (
    .clk(clk), .reset_N(reset_N), .sc(sc2));

  typedef struct packed {
    logic       is_done;
    logic [3:0] mask;
    logic [7:0] rcnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic push_start(input logic [3:0] m);
    exp_q.push_back('{is_done: 1'b0, mask: m, rcnt: 8'd0});
  endtask

  task automatic push_done(input logic [7:0] r);
    exp_q.push_back('{is_done: 1'b1, mask: 4'd0, rcnt: r});
  endtask

  task automatic tick();
    @(posedge clk); #1;
    s_start = 1'b0; s_abort = 1'b0; s_done_read = 1'b0; s_done = 4'd0;
  endtask

  // Monitor: every start or done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_N && (sc1.start_similarity_metric != 4'd0 || sc1.done_score_calc)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output start=%b done=%b expected=none",
                 sc1.start_similarity_metric, sc1.done_score_calc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_done) begin
          chk("done_pulse", 32'(sc1.done_score_calc), 32'd1);
          chk("done_round_cnt", 32'(sc1.round_cnt), 32'(e.rcnt));
        end else begin
          chk("start_mask", 32'(sc1.start_similarity_metric), 32'(e.mask));
          chk("start_no_done", 32'(sc1.done_score_calc), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_N = 1'b0;
    s_start = 1'b1; s_abort = 1'b0; s_done_read = 1'b0; s_vmask = 4'hF; s_done = 4'd0;
    #12;
    chk("rst_start", 32'(sc1.start_similarity_metric), 32'd0);
    chk("rst_done", 32'(sc1.done_score_calc), 32'd0);
    chk("rst_busy", 32'(sc1.busy), 32'd0);
    chk("rst_round_cnt", 32'(sc1.round_cnt), 32'd0);
    chk("rst_spurious", 32'(sc1.spurious_done), 32'd0);
    @(negedge clk);
    reset_N = 1'b1; s_start = 1'b0;
    tick();

    // Single round, mask 1011, dones at +3 and +5
    s_vmask = 4'b1011; s_start = 1'b1; push_start(4'b1011); tick();
    s_done_read = 1'b1; tick();
    tick();
    s_done = 4'b0001; tick();
    tick();
    chk("t1_busy_wait", 32'(sc1.busy), 32'd1);
    s_done = 4'b1010; push_done(8'd1); tick();
    chk("t1_busy_low", 32'(sc1.busy), 32'd0);
    chk("t1_round_cnt", 32'(sc1.round_cnt), 32'd1);

    // Three rounds, empty valid_mask, done_read during round 3
    s_vmask = 4'd0; s_start = 1'b1; push_start(4'b0001); tick();
    chk("t2_round_cnt_1", 32'(sc1.round_cnt), 32'd1);
    tick();
    s_done = 4'b0001; push_start(4'b0001); tick();
    tick();
    s_done = 4'b0001; push_start(4'b0001); tick();
    s_done_read = 1'b1; tick();
    s_done = 4'b0001; push_done(8'd3); tick();
    chk("t2_busy_low", 32'(sc1.busy), 32'd0);
    chk("t2_round_cnt", 32'(sc1.round_cnt), 32'd3);

    // done_read coincident with round-2 completion
    s_start = 1'b1; push_start(4'b0001); tick();
    tick();
    s_done = 4'b0001; push_start(4'b0001); tick();
    tick();
    s_done = 4'b0001; s_done_read = 1'b1; push_start(4'b0001); tick();
    chk("t3_busy_r3", 32'(sc1.busy), 32'd1);
    chk("t3_round_cnt", 32'(sc1.round_cnt), 32'd3);
    tick();
    s_done = 4'b0001; push_done(8'd3); tick();
    chk("t3_busy_low", 32'(sc1.busy), 32'd0);

    // Done while idle is spurious
    s_done = 4'b1000; tick();
    chk("idle_spurious", 32'(sc1.spurious_done), 32'd1);

    // Spurious done on unit 2 while pending = 0011
    s_vmask = 4'b0011; s_start = 1'b1; push_start(4'b0011); tick();
    chk("t4_spur_cleared", 32'(sc1.spurious_done), 32'd0);
    s_done_read = 1'b1; tick();
    s_done = 4'b0100; tick();
    chk("t4_spur_set", 32'(sc1.spurious_done), 32'd1);
    s_done = 4'b0001; tick();
    chk("t4_still_waiting", 32'(sc1.busy), 32'd1);
    s_done = 4'b0010; push_done(8'd1); tick();
    chk("t4_busy_low", 32'(sc1.busy), 32'd0);
    chk("t4_spur_sticky", 32'(sc1.spurious_done), 32'd1);

    // Abort coinciding with final done
    s_vmask = 4'd0; s_start = 1'b1; push_start(4'b0001); tick();
    chk("t5_spur_cleared", 32'(sc1.spurious_done), 32'd0);
    s_done_read = 1'b1; tick();
    s_done = 4'b0001; s_abort = 1'b1; tick();
    chk("t5_abort_idle", 32'(sc1.busy), 32'd0);
    chk("t5_abort_round_cnt", 32'(sc1.round_cnt), 32'd0);
    s_start = 1'b1; s_abort = 1'b1; tick();
    chk("t5_start_with_abort", 32'(sc1.busy), 32'd0);
    // Fresh sequence: last was flushed, so round 1 completion issues round 2
    s_vmask = 4'b0110; s_start = 1'b1; push_start(4'b0111); tick();
    chk("t5_fresh_round_cnt", 32'(sc1.round_cnt), 32'd1);
    tick();
    s_done = 4'b0111; push_start(4'b0111); tick();
    chk("t5_fresh_busy", 32'(sc1.busy), 32'd1);
    s_done_read = 1'b1; tick();
    s_done = 4'b0111; push_done(8'd2); tick();
    chk("t5_fresh_busy_low", 32'(sc1.busy), 32'd0);
    chk("t5_fresh_round_cnt2", 32'(sc1.round_cnt), 32'd2);

    // Five rounds: dut2 round counter saturates at 3
    s_vmask = 4'd0; s_start = 1'b1; push_start(4'b0001); tick();
    for (int r = 1; r <= 5; r++) begin
      chk("t6_round_cnt_w8", 32'(sc1.round_cnt), 32'(r));
      chk("t6_round_cnt_w2", 32'(sc2.round_cnt), (r < 3) ? 32'(r) : 32'd3);
      if (r == 5) s_done_read = 1'b1;
      tick();
      s_done = 4'b0001;
      if (r < 5) begin
        push_start(4'b0001);
      end else begin
        push_done(8'd5);
        #1;
        chk("t6_w2_done", 32'(sc2.done_score_calc), 32'd1);
        chk("t6_w2_round_cnt_final", 32'(sc2.round_cnt), 32'd3);
      end
      tick();
    end
    chk("t6_busy_low", 32'(sc1.busy), 32'd0);

    tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
